// File: rtl/constraint_seq_checker_if.sv
// Operand request / verdict handshake bundle for constraint_seq_checker.
// master drives requests and consumes results; slave is the checker.
interface constraint_seq_checker_if #(
  parameter int WA = 6,
  parameter int WB = 5,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] op_a;
  logic [WB-1:0] op_b;
  logic          out_valid;
  logic          out_ready;
  logic          x;
  logic [1:0]    fail_idx;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, x, fail_idx, pass_cnt, fail_cnt
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, x, fail_idx, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/constraint_seq_checker.sv
// Sequential checker: evaluates three constraints on captured operands, one per
// cycle, combines them with early exit, and keeps saturating pass/fail counts.
module constraint_seq_checker #(
  parameter int WA    = 6,
  parameter int WB    = 5,
  parameter int PW    = 8,
  parameter int K     = 5,
  parameter int SHAMT = 1,
  parameter int C0    = 36,
  parameter int MODE  = 0,
  parameter int CW    = 8
) (
  input logic                clk,
  input logic                rst_n,
  constraint_seq_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    idx_reg, idx_next;
  logic [WA-1:0] a_reg, a_next;
  logic [WB-1:0] b_reg, b_next;
  logic          x_reg, x_next;
  logic [1:0]    fail_idx_reg, fail_idx_next;
  logic [CW-1:0] pass_cnt_reg, pass_cnt_next;
  logic [CW-1:0] fail_cnt_reg, fail_cnt_next;

  logic [PW-1:0] sum;
  logic [PW-1:0] prod;
  logic          c0, c1, c2, cur, decide;

  // Each arithmetic step is truncated to PW bits.
  assign sum  = PW'(b_reg) + PW'(K);
  assign prod = sum * PW'(a_reg);

  assign c0 = (a_reg != {WA{1'b1}}) || (C0 != 0);
  assign c1 = (prod != '0);
  assign c2 = ((a_reg >> SHAMT) != '0);

  always_comb begin
    case (idx_reg)
      2'd0:    cur = c0;
      2'd1:    cur = c1;
      default: cur = c2;
    endcase
  end

  // A constraint decides early when it disagrees with the neutral value of the combine.
  assign decide = (MODE == 0) ? !cur : cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= 2'd0;
      a_reg        <= '0;
      b_reg        <= '0;
      x_reg        <= 1'b0;
      fail_idx_reg <= 2'd0;
      pass_cnt_reg <= '0;
      fail_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      x_reg        <= x_next;
      fail_idx_reg <= fail_idx_next;
      pass_cnt_reg <= pass_cnt_next;
      fail_cnt_reg <= fail_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    x_next        = x_reg;
    fail_idx_next = fail_idx_reg;
    pass_cnt_next = pass_cnt_reg;
    fail_cnt_next = fail_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.op_a;
          b_next     = bus.op_b;
          idx_next   = 2'd0;
          state_next = EVAL;
        end
      end
      EVAL: begin
        if (decide || idx_reg == 2'd2) begin
          x_next        = decide ? cur : (MODE == 0);
          fail_idx_next = decide ? idx_reg : 2'd3;
          state_next    = DONE;
        end else begin
          idx_next = idx_reg + 2'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
          if (x_reg) begin
            if (pass_cnt_reg != {CW{1'b1}}) pass_cnt_next = pass_cnt_reg + 1'b1;
          end else begin
            if (fail_cnt_reg != {CW{1'b1}}) fail_cnt_next = fail_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.x         = x_reg;
  assign bus.fail_idx  = fail_idx_reg;
  assign bus.pass_cnt  = pass_cnt_reg;
  assign bus.fail_cnt  = fail_cnt_reg;

endmodule

// File: tb/tb_constraint_seq_checker.sv
// Scoreboard bench: one default-parameter checker and one MODE=1/C0=0/CW=2 checker.
module tb_constraint_seq_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  constraint_seq_checker_if #(.WA(6), .WB(5), .CW(8)) bus0 ();
  constraint_seq_checker_if #(.WA(6), .WB(5), .CW(2)) bus1 ();

  constraint_seq_checker u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  constraint_seq_checker #(.MODE(1), .C0(0), .CW(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int         sel = 0;
  logic       iv = 1'b0;
  logic       ordy = 1'b0;
  logic [5:0] opa = '0;
  logic [4:0] opb = '0;

  assign bus0.in_valid  = iv && (sel == 0);
  assign bus1.in_valid  = iv && (sel == 1);
  assign bus0.out_ready = ordy && (sel == 0);
  assign bus1.out_ready = ordy && (sel == 1);
  assign bus0.op_a = opa;
  assign bus1.op_a = opa;
  assign bus0.op_b = opb;
  assign bus1.op_b = opb;

  logic       o_ir, o_ov, o_x;
  logic [1:0] o_fi;
  int         o_pass, o_fail;
  assign o_ir   = (sel == 0) ? bus0.in_ready  : bus1.in_ready;
  assign o_ov   = (sel == 0) ? bus0.out_valid : bus1.out_valid;
  assign o_x    = (sel == 0) ? bus0.x         : bus1.x;
  assign o_fi   = (sel == 0) ? bus0.fail_idx  : bus1.fail_idx;
  assign o_pass = (sel == 0) ? int'(bus0.pass_cnt) : int'(bus1.pass_cnt);
  assign o_fail = (sel == 0) ? int'(bus0.fail_cnt) : int'(bus1.fail_cnt);

  typedef struct {
    int x;
    int fi;
    int lat;
  } exp_t;
  exp_t exp_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_pass[2];
  int exp_fail[2];

  task automatic check(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference evaluation with plain integer arithmetic.
  function automatic exp_t model(input int a, input int b, input int mode, input int c0lit);
    exp_t e;
    int   c[3];
    c[0] = ((a != 63) || (c0lit != 0)) ? 1 : 0;
    c[1] = ((((b + 5) % 256) * a) % 256 != 0) ? 1 : 0;
    c[2] = ((a / 2) != 0) ? 1 : 0;
    e.x  = (mode == 0) ? 1 : 0;
    e.fi = 3;
    for (int i = 2; i >= 0; i--) begin
      if ((mode == 0 && c[i] == 0) || (mode == 1 && c[i] == 1)) begin
        e.x  = c[i];
        e.fi = i;
      end
    end
    e.lat = (e.fi == 3) ? 3 : e.fi + 1;
    return e;
  endfunction

  task automatic do_op(input int s, input int a, input int b, input int hold);
    exp_t e;
    int   lat;
    int   cmax;
    sel  = s;
    cmax = (s == 0) ? 255 : 3;
    @(posedge clk); #1;
    check("in_ready_idle", o_ir, 1);
    opa = 6'(a);
    opb = 5'(b);
    iv  = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(a, b, s, (s == 0) ? 36 : 0));
    // Requests during EVAL carry junk operands and must be ignored.
    opa = 6'($urandom);
    opb = 5'($urandom);
    lat = 0;
    while (!o_ov && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    iv = 1'b0;
    e  = exp_q.pop_front();
    check("latency", lat, e.lat);
    check("x", o_x, e.x);
    check("fail_idx", o_fi, e.fi);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", o_ov, 1);
      check("hold_x", o_x, e.x);
      check("hold_fail_idx", o_fi, e.fi);
      check("hold_in_ready", o_ir, 0);
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    if (e.x == 1) begin
      if (exp_pass[s] < cmax) exp_pass[s]++;
    end else begin
      if (exp_fail[s] < cmax) exp_fail[s]++;
    end
    check("post_valid", o_ov, 0);
    check("post_in_ready", o_ir, 1);
    check("pass_cnt", o_pass, exp_pass[s]);
    check("fail_cnt", o_fail, exp_fail[s]);
    $display("txn dut%0d a=%02h b=%02h hold=%0d -> x=%0d fail_idx=%0d lat=%0d pass=%0d fail=%0d",
             s, a, b, hold, o_x, o_fi, lat, o_pass, o_fail);
  endtask

  task automatic check_reset_state(input int s, input string tag);
    sel = s;
    #0;
    check({tag, "_x"}, o_x, 0);
    check({tag, "_fail_idx"}, o_fi, 0);
    check({tag, "_out_valid"}, o_ov, 0);
    check({tag, "_pass_cnt"}, o_pass, 0);
    check({tag, "_fail_cnt"}, o_fail, 0);
    check({tag, "_in_ready"}, o_ir, 1);
  endtask

  initial begin
    exp_pass = '{0, 0};
    exp_fail = '{0, 0};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_state(0, "rst0");
    check_reset_state(1, "rst1");

    do_op(0, 6'h02, 5'h03, 0);
    do_op(0, 6'h00, 5'h03, 0);
    do_op(0, 6'h08, 5'h1B, 0);
    do_op(0, 6'h01, 5'h00, 5);
    do_op(0, 6'h3F, 5'h00, 1);
    do_op(1, 6'h3F, 5'h00, 0);
    do_op(1, 6'h3F, 5'h1B, 2);
    do_op(1, 6'h01, 5'h00, 0);

    for (int i = 0; i < 12; i++) begin
      do_op(i % 2, int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 2)));
    end

    // Push the narrow counter past its ceiling.
    for (int i = 0; i < 4; i++) do_op(1, 6'h01, 5'h00, 0);
    check("pass_saturated", o_pass, 3);

    // Abort mid-evaluation: no result and no counter movement may follow.
    sel = 0;
    @(posedge clk); #1;
    opa = 6'h02;
    opb = 5'h03;
    iv  = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_pass = '{0, 0};
    exp_fail = '{0, 0};
    check_reset_state(0, "abort0");
    check_reset_state(1, "abort1");
    sel = 0;
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_no_valid", o_ov, 0);
    end
    do_op(0, 6'h02, 5'h03, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/constraint_seq_checker.md
CONSTRAINT_SEQ_CHECKER -- requirements
Module: constraint_seq_checker

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WA, 6: width of operand a.
- WB, 5: width of operand b.
- PW, 8: arithmetic width for constraint 1.
- K, 5: additive constant for constraint 1.
- SHAMT, 1: right-shift amount for constraint 2.
- C0, 36 (0x24): literal for constraint 0.
- MODE, 0: combine mode; 0 = AND with early exit on first 0; 1 = OR with early exit on first 1.
- CW, 8: width of each statistics counter.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock; all state on its rising edge.
- rst_n, in, 1: reset; synchronous, active-low.
- in_valid, in, 1: operand request.
- in_ready, out, 1: block can accept.
- op_a, in, WA: operand a.
- op_b, in, WB: operand b.
- out_valid, out, 1: result available.
- out_ready, in, 1: consumer accepts the result.
- x, out, 1: combined verdict.
- fail_idx, out, 2: index of the deciding constraint, 0..2, or 3 if no constraint decided early.
- pass_cnt, out, CW: count of results with x=1.
- fail_cnt, out, CW: count of results with x=0.

Function
REQ-003 Operands SHALL be captured into internal registers on a cycle with in_valid=1 and in_ready=1; op_a/op_b SHALL be ignored at all other times.
REQ-004 in_ready SHALL equal 1 only in state IDLE.
REQ-005 The FSM SHALL have states IDLE, EVAL, DONE:
- IDLE -> EVAL on accept.
- EVAL -> DONE after the deciding or last constraint.
- DONE -> IDLE on out_valid=1 and out_ready=1.
REQ-006 EVAL SHALL evaluate exactly one constraint per cycle, in order 0, 1, 2, using a 2-bit index reset to 0 on each accept.
REQ-007 Constraint 0 SHALL be 1 iff (a != all-ones of WA bits) or (C0 != 0).
REQ-008 Constraint 1 SHALL be 1 iff ((b + K) * a), computed with every term zero-extended to PW bits and truncated modulo 2^PW after each operation, is nonzero.
REQ-009 Constraint 2 SHALL be 1 iff the logical shift (a >> SHAMT), at WA bits, is nonzero.
REQ-010 MODE=0: the first constraint evaluating to 0 SHALL end EVAL with x=0 and fail_idx set to that index; if all three are 1, x=1 and fail_idx=3.
REQ-011 MODE=1: the first constraint evaluating to 1 SHALL end EVAL with x=1 and fail_idx set to that index; if all three are 0, x=0 and fail_idx=3.
REQ-012 Latency: with the accept edge in cycle T and the decision at index k (0..2), out_valid SHALL rise in cycle T+k+2, i.e. k+1 EVAL cycles.
REQ-013 out_valid SHALL be 1 only in DONE.
REQ-014 x and fail_idx SHALL be held stable from out_valid rising until the handshake completes, regardless of out_ready.
REQ-015 On the DONE handshake edge, pass_cnt (x=1) or fail_cnt (x=0) SHALL increment by 1, saturating at 2^CW-1 with no wrap.
REQ-016 There SHALL be no same-cycle DONE-to-accept bypass; the next accept occurs at the earliest one cycle after the handshake.
REQ-017 in_valid asserted during EVAL or DONE SHALL have no effect; no operand queueing.
REQ-018 x, fail_idx and out_valid SHALL be registered outputs with no combinational path from any input.

Reset
REQ-019 When rst_n=0 at a clock edge:
- FSM -> IDLE.
- x=0, fail_idx=0, out_valid=0, pass_cnt=0, fail_cnt=0, constraint index 0.
- in_ready SHALL be 1 in the first cycle after reset is released.
REQ-020 Reset asserted during EVAL or DONE SHALL abort the operation; no counter updates and no out_valid pulse for that operand.
REQ-021 Before the first clock edge with rst_n=0, output values are unspecified.

Verification (defaults, MODE=0 unless noted)
REQ-022 a=0x02, b=0x03 -> c0=1; c1=(8*2)=16; c2=1; x=1, fail_idx=3, out_valid at T+4, pass_cnt=1.
REQ-023 a=0x00, b=0x03 -> c1 product=0; x=0, fail_idx=1, out_valid at T+3; constraint 2 never evaluated; fail_cnt=1.
REQ-024 a=0x08, b=0x1B -> (27+5)=32; 32*8=256 mod 256 = 0; x=0, fail_idx=1, proving PW truncation.
REQ-025 a=0x01, b=0x00, out_ready held 0 for 5 cycles -> x=0, fail_idx=2; out_valid, x and fail_idx stable for 5 cycles; in_ready=0 throughout; one fail_cnt increment on the handshake.
REQ-026 MODE=1, a=0x3F, C0=0 -> c0=0; c1=(b+K)*63 with b=0 = 315 mod 256 = 59, nonzero; x=1, fail_idx=1.
REQ-027 Reset during EVAL, and CW=2 with four x=1 results -> after reset all outputs are 0 and in_ready=1; pass_cnt saturates at 3.
